// File: rtl/noc_inject_queue_pkg.sv
// Shared definitions for the node injection queue: flit layout, node count,
// output FSM state type and small flit field helpers.
package noc_ni_pkg;

    localparam int unsigned PL       = 24;
    localparam int unsigned NODES    = 9;
    localparam int unsigned DEST_OFF = 0;
    localparam int unsigned DEST_W   = 4;
    localparam int unsigned SRC_OFF  = 4;
    localparam int unsigned SRC_W    = 4;

    // Bit 0 is the MSB; DEST occupies [0:3], SRC [4:7], payload [8:PL-1].
    typedef logic [0:PL-1] flit_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } out_state_e;

    function automatic logic [DEST_W-1:0] flit_dest(input flit_t f);
        return f[DEST_OFF +: DEST_W];
    endfunction

    function automatic flit_t stamp_src(input flit_t f, input logic [SRC_W-1:0] src);
        flit_t r;
        r = f;
        r[SRC_OFF +: SRC_W] = src;
        return r;
    endfunction

endpackage

// File: rtl/noc_inject_queue_if.sv
// Core-side and router-side flit handshake of the injection queue.
interface noc_inject_queue_if;

    noc_ni_pkg::flit_t core_flit;
    logic              core_valid;
    logic              core_ready;
    noc_ni_pkg::flit_t noc_flit;
    logic              noc_valid;
    logic              noc_avail;

    modport slave (
        input  core_flit, core_valid, noc_avail,
        output core_ready, noc_flit, noc_valid
    );

    modport master (
        output core_flit, core_valid, noc_avail,
        input  core_ready, noc_flit, noc_valid
    );

endinterface

// File: rtl/noc_inject_queue_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head is read combinationally.
module ni_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    // Pointer update; pointers wrap modulo 2*DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (rst_n && push) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count = wptr - rptr;

endmodule

// File: rtl/noc_inject_queue.sv
// Injection queue between a core flit output and a router local input:
// stamps the source node, drops misaddressed flits, buffers in a FIFO and
// presents flits through a registered output stage.
module noc_inject_queue #(
    parameter int unsigned NODE_ID = 0,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    noc_inject_queue_if.slave      ni,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [7:0]             drop_cnt
);

    import noc_ni_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          fifo_full;
    logic          fifo_empty;
    logic          accept;
    logic          misaddr;
    logic          push;
    logic          pop;
    flit_t         wr_flit;
    flit_t         head_flit;
    flit_t         out_flit;
    out_state_e    state;
    logic [CW-1:0] count;

    // Ready depends only on FIFO pointers, never on noc_avail.
    assign ni.core_ready = !fifo_full;
    assign accept        = rst_n && ni.core_valid && ni.core_ready;
    assign misaddr       = (flit_dest(ni.core_flit) >= DEST_W'(NODES));
    assign push          = accept && !misaddr;
    assign wr_flit       = stamp_src(ni.core_flit, SRC_W'(NODE_ID));
    // Refill the output register when it is empty or being transferred.
    assign pop           = !fifo_empty && ((state == ST_IDLE) || ni.noc_avail);

    ni_fifo #(
        .WIDTH (PL),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wr_flit),
        .pop   (pop),
        .rdata (head_flit),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    // Output FSM: load the output register from the FIFO head and hold it until transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            out_flit <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        out_flit <= head_flit;
                        state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (ni.noc_avail) begin
                        if (!fifo_empty) out_flit <= head_flit;
                        else             state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Saturating count of discarded misaddressed flits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (accept && misaddr && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign ni.noc_valid = (state == ST_SEND);
    assign ni.noc_flit  = out_flit;
    assign occupancy    = count;

endmodule

// File: tb/tb_noc_inject_queue.sv
// Self-checking bench for noc_inject_queue (NODE_ID=1, DEPTH=4).
module tb_noc_inject_queue;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned NODE_ID = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] occupancy;
    logic [7:0] drop_cnt;

    always #5 clk = ~clk;

    noc_inject_queue_if ni ();

    noc_inject_queue #(
        .NODE_ID (NODE_ID),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ni        (ni),
        .occupancy (occupancy),
        .drop_cnt  (drop_cnt)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [23:0] exp_q[$];
    int          held;
    int          drop_model;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [23:0] mk(input logic [3:0] d, input logic [3:0] s, input logic [15:0] p);
        return {d, s, p};
    endfunction

    task automatic drive(input logic v, input logic [3:0] d, input logic [15:0] p);
        logic [3:0] junk_src;
        junk_src      = 4'($urandom);
        ni.core_valid = v;
        ni.core_flit  = {d, junk_src, p};
    endtask

    // One clock: sample handshakes at negedge, update the reference queue, advance.
    task automatic step();
        logic        acc;
        logic        xfer;
        logic [23:0] f;
        logic [23:0] want;
        @(negedge clk);
        chk("core_ready", 32'(ni.core_ready), 32'(held != int'(DEPTH) + 1));
        chk("occ_bound", 32'(occupancy <= 3'(DEPTH)), 32'd1);
        if (held == 0) chk("valid_when_empty", 32'(ni.noc_valid), 32'd0);
        acc  = ni.core_valid && ni.core_ready;
        xfer = ni.noc_valid && ni.noc_avail;
        if (xfer) begin
            chk("xfer_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                chk("noc_flit_order", 32'(ni.noc_flit), 32'(want));
                held--;
            end
        end
        if (acc) begin
            f = ni.core_flit;
            if (f[23:20] >= 4'd9) begin
                if (drop_model < 255) drop_model++;
            end else begin
                exp_q.push_back(mk(f[23:20], 4'(NODE_ID), f[15:0]));
                held++;
            end
        end
        @(posedge clk);
        #1;
        chk("drop_cnt", 32'(drop_cnt), 32'(drop_model));
    endtask

    task automatic model_clear();
        exp_q.delete();
        held       = 0;
        drop_model = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n         = 1'b0;
        ni.core_valid = 1'b0;
        ni.core_flit  = '0;
        ni.noc_avail  = 1'b0;
        model_clear();

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_valid", 32'(ni.noc_valid), 32'd0);
        chk("rst_flit", 32'(ni.noc_flit), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        rst_n = 1'b1;
        chk("rst_ready", 32'(ni.core_ready), 32'd1);

        // Single flit, minimum latency, source stamping
        ni.noc_avail = 1'b1;
        drive(1'b1, 4'd3, 16'hABCD);
        step();
        ni.core_valid = 1'b0;
        chk("lat_occ1", 32'(occupancy), 32'd1);
        chk("lat_valid0", 32'(ni.noc_valid), 32'd0);
        step();
        chk("lat_valid1", 32'(ni.noc_valid), 32'd1);
        chk("lat_flit", 32'(ni.noc_flit), 32'h0031ABCD);
        chk("lat_occ0", 32'(occupancy), 32'd0);
        step();
        chk("lat_done", 32'(ni.noc_valid), 32'd0);

        // Fill with router stalled
        ni.noc_avail = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'(i), 16'h1000 + 16'(i));
            step();
        end
        chk("fill4_occ", 32'(occupancy), 32'd3);
        chk("fill4_valid", 32'(ni.noc_valid), 32'd1);
        chk("fill4_head", 32'(ni.noc_flit), 32'(mk(4'd0, 4'd1, 16'h1000)));
        drive(1'b1, 4'd4, 16'h1004);
        step();
        chk("fill5_occ", 32'(occupancy), 32'd4);
        chk("fill5_ready", 32'(ni.core_ready), 32'd0);
        drive(1'b1, 4'd5, 16'h1005);
        step();
        chk("fill6_occ", 32'(occupancy), 32'd4);
        chk("fill6_hold", 32'(ni.noc_flit), 32'(mk(4'd0, 4'd1, 16'h1000)));
        ni.core_valid = 1'b0;

        // Drain: five back-to-back transfers in push order
        ni.noc_avail = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("drain_valid", 32'(ni.noc_valid), 32'd1);
            step();
        end
        chk("drain_idle", 32'(ni.noc_valid), 32'd0);
        chk("drain_occ", 32'(occupancy), 32'd0);
        chk("drain_model", 32'(exp_q.size()), 32'd0);

        // Misaddressed flits
        drive(1'b1, 4'd9, 16'h5555);
        step();
        drive(1'b1, 4'd15, 16'h6666);
        step();
        ni.core_valid = 1'b0;
        step();
        chk("drop_novalid", 32'(ni.noc_valid), 32'd0);
        chk("drop_two", 32'(drop_cnt), 32'd2);
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 4'(9 + $urandom_range(0, 6)), 16'($urandom));
            step();
        end
        ni.core_valid = 1'b0;
        chk("drop_sat", 32'(drop_cnt), 32'd255);
        chk("drop_ready", 32'(ni.core_ready), 32'd1);

        // Streaming at full rate
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 4'($urandom_range(0, 8)), 16'($urandom));
            step();
            chk("stream_occ", 32'(occupancy <= 3'd1), 32'd1);
            if (i >= 1) chk("stream_valid", 32'(ni.noc_valid), 32'd1);
        end
        ni.core_valid = 1'b0;

        // Random traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            ni.noc_avail = ($urandom_range(0, 3) != 0);
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 11)), 16'($urandom));
            step();
        end
        ni.core_valid = 1'b0;
        ni.noc_avail  = 1'b1;
        for (int i = 0; i < int'(DEPTH) + 4 && exp_q.size() > 0; i++) step();
        chk("final_drain", 32'(exp_q.size()), 32'd0);
        step();
        chk("final_idle", 32'(ni.noc_valid), 32'd0);

        // Reset with queued flits and a valid output
        ni.noc_avail = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'd7, 16'h2000 + 16'(i));
            step();
        end
        chk("prerst_occ", 32'(occupancy), 32'd3);
        chk("prerst_valid", 32'(ni.noc_valid), 32'd1);
        drive(1'b1, 4'd2, 16'h3333);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_occ", 32'(occupancy), 32'd0);
        chk("midrst_valid", 32'(ni.noc_valid), 32'd0);
        chk("midrst_drop", 32'(drop_cnt), 32'd0);
        chk("midrst_flit", 32'(ni.noc_flit), 32'd0);
        model_clear();
        rst_n         = 1'b1;
        ni.core_valid = 1'b0;
        ni.noc_avail  = 1'b1;
        chk("postrst_ready", 32'(ni.core_ready), 32'd1);
        step();
        step();
        chk("postrst_valid", 32'(ni.noc_valid), 32'd0);
        chk("postrst_occ", 32'(occupancy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/noc_inject_queue.md
NOC_INJECT_QUEUE -- requirements
Module: noc_inject_queue

Interface
REQ-001 Parameter NODE_ID, default 0, node index 0..8 stamped as flit source.
REQ-002 Parameter DEPTH, default 4, FIFO entries, power of two, 2..16.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 core_flit  input  PL  flit from core, index [0:PL-1].
REQ-006 core_valid  input  1  core_flit valid this cycle.
REQ-007 core_ready  output  1  queue accepts a flit this cycle.
REQ-008 noc_flit  output  PL  flit to router local input port.
REQ-009 noc_valid  output  1  noc_flit valid.
REQ-010 noc_avail  input  1  router local port available; a flit transfers when noc_valid && noc_avail.
REQ-011 occupancy  output  clog2(DEPTH)+1  entries held in the FIFO, excluding the output register.
REQ-012 drop_cnt  output  8  count of discarded misaddressed flits.

Function
REQ-013 Flit fields: DEST = bits [0:3], SRC = bits [4:7], payload = bits [8:PL-1]; PL >= 16.
REQ-014 core_ready = (occupancy != DEPTH), decoded from registered state only, with no combinational path from noc_avail.
REQ-015 Accept on core_valid && core_ready; on write, SRC is overwritten with NODE_ID and DEST and payload are stored unchanged.
REQ-016 An accepted flit with DEST >= 9 is not stored, drop_cnt increments by 1 and saturates at 255, and core_ready is unaffected.
REQ-017 FIFO read/write pointers are clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full and empty are decoded from the MSB difference.
REQ-018 Output FSM state IDLE: noc_valid = 0; if the FIFO is non-empty, pop the head into the output register and go to SEND.
REQ-019 Output FSM state SEND: noc_valid = 1 and noc_flit is held stable until transfer.
REQ-020 On transfer in SEND: if the FIFO is non-empty, pop the next flit in the same cycle and stay in SEND (one flit per cycle sustained); otherwise go to IDLE.
REQ-021 noc_avail low in SEND: hold state, noc_flit and noc_valid unchanged, with no pop.
REQ-022 Minimum latency: flit accepted at edge N appears with noc_valid = 1 in the cycle following edge N+1.
REQ-023 Simultaneous push and pop: occupancy is unchanged; push when full is impossible because core_ready = 0.
REQ-024 Flit order preserved; no flit duplicated or lost except per REQ-016.

Reset
REQ-025 On rst_n low at a clock edge: pointers = 0, occupancy = 0, state = IDLE, noc_valid = 0, noc_flit = 0, drop_cnt = 0.
REQ-026 core_ready = 1 in the cycle after reset.
REQ-027 Reset mid-transfer discards all queued flits and the output register contents.
REQ-028 No flit is accepted in a cycle where rst_n = 0.

Structure
REQ-029 Shared package noc_ni_pkg holds PL, NODES = 9, DEST/SRC field offsets and widths, and the output FSM state enum.
REQ-030 One sub-module, ni_fifo (parameterised width and depth, push/pop/full/empty/count), is instantiated once.
REQ-031 The block sits between the cpu_with_ram flitOut port and the noc core_inputs entry for its node.

Verification
REQ-032 Reset, then one flit DEST=3 payload=0xABCD with NODE_ID=1, noc_avail=1 -> noc_valid two cycles later, noc_flit with DEST=3, SRC=1, payload=0xABCD, occupancy returns to 0.
REQ-033 noc_avail=0, push 4 flits with DEPTH=4 -> 1 flit in the output register, occupancy=3; the 5th push fills the FIFO, after which core_ready=0 and a 6th core_valid is not accepted.
REQ-034 From the REQ-033 full state, raise noc_avail=1 -> 5 flits out on consecutive cycles in push order, then noc_valid=0.
REQ-035 Push DEST=9, then DEST=15 -> no noc_valid, drop_cnt=2; 300 such pushes -> drop_cnt=255.
REQ-036 Continuous push with noc_avail=1 -> one flit per cycle throughput, occupancy stays at or below 1, order preserved.
REQ-037 Assert rst_n=0 with occupancy=3 and noc_valid=1 -> next cycle occupancy=0, noc_valid=0, drop_cnt=0.
